// File: rtl/c499_sec_pkg.sv
// Shared constants and check-bit function for the c499 SEC encode/decode path.
// Each data bit maps to a unique check-bit syndrome of weight >= 2.
package c499_sec_pkg;

    localparam int DW     = 32;
    localparam int CW     = 8;
    localparam int CODE_W = DW + CW;
    localparam int CNT_W  = 16;
    localparam int POS_W  = 6;

    localparam logic [POS_W-1:0] POS_MAX = 6'd39;

    localparam logic [DW-1:0] MASK [0:CW-1] = '{
        32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000,
        32'h91919191, 32'h32323232, 32'h64646464, 32'hC8C8C8C8
    };

    function automatic logic [CW-1:0] sec_check(input logic [DW-1:0] data);
        logic [CW-1:0] chk;
        chk = '0;
        for (int j = 0; j < CW; j++) begin
            chk[j] = ^(data & MASK[j]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/c499_sec_encoder_if.sv
// Stream and statistics bundle of the c499 SEC encoder.
// master = stimulus side, slave = encoder.
interface c499_sec_encoder_if;
    import c499_sec_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic                 inj_en;
    logic                 inj_sweep;
    logic [POS_W-1:0]     inj_pos;
    logic                 out_valid;
    logic                 out_ready;
    logic [CODE_W-1:0]    out_code;
    logic                 out_rd_en;
    logic                 out_injected;
    logic [CNT_W-1:0]     word_cnt;
    logic [CNT_W-1:0]     inj_cnt;

    modport master (
        output in_valid, in_data, inj_en, inj_sweep, inj_pos, out_ready,
        input  in_ready, out_valid, out_code, out_rd_en, out_injected, word_cnt, inj_cnt
    );

    modport slave (
        input  in_valid, in_data, inj_en, inj_sweep, inj_pos, out_ready,
        output in_ready, out_valid, out_code, out_rd_en, out_injected, word_cnt, inj_cnt
    );

endinterface

// File: rtl/c499_sec_gen.sv
// Combinational check-bit generator: one parity tree per check bit.
module c499_sec_gen
    import c499_sec_pkg::*;
(
    input  logic [DW-1:0] data,
    output logic [CW-1:0] check
);

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_chk
            assign check[gi] = ^(data & MASK[gi]);
        end
    endgenerate

endmodule

// File: rtl/c499_sec_encoder.sv
// Two-stage valid/ready c499 SEC encoder with optional single-bit fault injection
// and saturating word / injection counters.
module c499_sec_encoder
    import c499_sec_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    c499_sec_encoder_if.slave bus
);

    logic                 s1_v_reg;
    logic [DW-1:0]        s1_data_reg;
    logic                 s1_flip_reg;
    logic [POS_W-1:0]     s1_pos_reg;
    logic                 s2_v_reg;
    logic [CODE_W-1:0]    s2_code_reg;
    logic                 s2_inj_reg;
    logic [POS_W-1:0]     sweep_cnt_reg;
    logic [CNT_W-1:0]     word_cnt_reg;
    logic [CNT_W-1:0]     inj_cnt_reg;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 in_acc;
    logic                 out_acc;
    logic [POS_W-1:0]     pos_next;
    logic                 flip_next;
    logic [CW-1:0]        check;
    logic [CODE_W-1:0]    flip_mask;
    logic [CODE_W-1:0]    code_next;

    assign s2_adv  = !s2_v_reg || bus.out_ready;
    assign s1_adv  = !s1_v_reg || s2_adv;
    assign in_acc  = bus.in_valid && s1_adv;
    assign out_acc = s2_v_reg && bus.out_ready;

    // Position is resolved at S1 so the sweep value travels with its word.
    assign pos_next  = bus.inj_sweep ? sweep_cnt_reg : bus.inj_pos;
    assign flip_next = bus.inj_en && (pos_next <= POS_MAX);

    c499_sec_gen u_gen (
        .data  (s1_data_reg),
        .check (check)
    );

    assign flip_mask = s1_flip_reg ? ({{(CODE_W-1){1'b0}}, 1'b1} << s1_pos_reg) : '0;
    assign code_next = {check, s1_data_reg} ^ flip_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_reg      <= 1'b0;
            s1_data_reg   <= '0;
            s1_flip_reg   <= 1'b0;
            s1_pos_reg    <= '0;
            s2_v_reg      <= 1'b0;
            s2_code_reg   <= '0;
            s2_inj_reg    <= 1'b0;
            sweep_cnt_reg <= '0;
            word_cnt_reg  <= '0;
            inj_cnt_reg   <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data_reg <= bus.in_data;
                    s1_flip_reg <= flip_next;
                    s1_pos_reg  <= pos_next;
                end
            end
            if (in_acc && bus.inj_en && bus.inj_sweep) begin
                sweep_cnt_reg <= (sweep_cnt_reg == POS_MAX) ? '0 : sweep_cnt_reg + 1'b1;
            end
            if (s2_adv) begin
                s2_v_reg   <= s1_v_reg;
                s2_inj_reg <= s1_v_reg && s1_flip_reg;
                if (s1_v_reg) begin
                    s2_code_reg <= code_next;
                end
            end
            // Statistics saturate rather than wrap so long campaigns stay meaningful.
            if (out_acc && (word_cnt_reg != '1)) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            if (out_acc && s2_inj_reg && (inj_cnt_reg != '1)) begin
                inj_cnt_reg <= inj_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready     = s1_adv;
    assign bus.out_valid    = s2_v_reg;
    assign bus.out_code     = s2_code_reg;
    assign bus.out_rd_en    = s2_v_reg;
    assign bus.out_injected = s2_inj_reg;
    assign bus.word_cnt     = word_cnt_reg;
    assign bus.inj_cnt      = inj_cnt_reg;

endmodule
